// File: rtl/uart_bus_pkg.sv
// Shared definitions for the serial-to-bus bridge.
// Holds the bridge state encoding, the command/response byte values
// and the bus byte-enable pattern used during a strobe.
package uart_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        BUS,
        RDWAIT,
        RESP
    } state_e;

    localparam logic [7:0] CMD_WRITE     = 8'h57;
    localparam logic [7:0] CMD_READ      = 8'h52;
    localparam logic [7:0] RSP_ACK       = 8'h4B;
    localparam logic [3:0] BUS_SIZE_WORD = 4'b1111;

    // True for the two bytes that may open a frame.
    function automatic logic is_command(input logic [7:0] b);
        return (b == CMD_WRITE) || (b == CMD_READ);
    endfunction

endpackage

// File: rtl/uart.sv
// 8N1 UART core with valid/ready byte interfaces on both directions.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   serial_rx/serial_tx serial lines (tx idles high)
//   data_in*            byte to transmit, taken when valid & ready
//   data_out*           received byte, held until valid & ready
// A received byte is held in a one-entry buffer; a byte that completes
// while the buffer is still occupied is discarded.
module uart #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_rx,
    output logic       serial_tx,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready
);

    localparam int CPB    = CLOCK_FREQ / BAUD_RATE;
    localparam int CW     = (CPB > 2) ? $clog2(CPB) : 1;
    // The two-flop synchroniser adds latency; shorten the first wait so
    // samples land near the middle of each bit.
    localparam int HALF_I = (CPB / 2 > 2) ? CPB / 2 - 2 : 0;
    localparam logic [CW-1:0] BIT_LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF     = CW'(HALF_I);

    logic [1:0]    rx_sync_q;
    logic          rx_busy_q;
    logic [CW-1:0] rx_cnt_q;
    logic [3:0]    rx_bit_q;
    logic [7:0]    rx_shift_q;
    logic [7:0]    out_data_q;
    logic          out_valid_q;

    logic [9:0]    tx_shift_q;
    logic [CW-1:0] tx_cnt_q;
    logic [3:0]    tx_left_q;

    assign data_out       = out_data_q;
    assign data_out_valid = out_valid_q;
    assign data_in_ready  = (tx_left_q == 4'd0);
    assign serial_tx      = tx_shift_q[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync_q   <= 2'b11;
            rx_busy_q   <= 1'b0;
            rx_cnt_q    <= '0;
            rx_bit_q    <= 4'd0;
            rx_shift_q  <= 8'h00;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
        end else begin
            rx_sync_q <= {rx_sync_q[0], serial_rx};
            if (out_valid_q && data_out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (!rx_busy_q) begin
                if (!rx_sync_q[1]) begin
                    rx_busy_q <= 1'b1;
                    rx_cnt_q  <= HALF;
                    rx_bit_q  <= 4'd0;
                end
            end else if (rx_cnt_q != '0) begin
                rx_cnt_q <= rx_cnt_q - 1'b1;
            end else begin
                rx_cnt_q <= BIT_LAST;
                if (rx_bit_q == 4'd0) begin
                    // Line back high at mid start bit: glitch, not a byte.
                    if (rx_sync_q[1]) rx_busy_q <= 1'b0;
                    else              rx_bit_q  <= 4'd1;
                end else if (rx_bit_q != 4'd9) begin
                    rx_shift_q <= {rx_sync_q[1], rx_shift_q[7:1]};
                    rx_bit_q   <= rx_bit_q + 4'd1;
                end else begin
                    rx_busy_q <= 1'b0;
                    if (rx_sync_q[1] && (!out_valid_q || data_out_ready)) begin
                        out_data_q  <= rx_shift_q;
                        out_valid_q <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_shift_q <= '1;
            tx_cnt_q   <= '0;
            tx_left_q  <= 4'd0;
        end else if (tx_left_q == 4'd0) begin
            if (data_in_valid) begin
                tx_shift_q <= {1'b1, data_in, 1'b0};
                tx_left_q  <= 4'd10;
                tx_cnt_q   <= BIT_LAST;
            end
        end else if (tx_cnt_q != '0) begin
            tx_cnt_q <= tx_cnt_q - 1'b1;
        end else begin
            tx_shift_q <= {1'b1, tx_shift_q[9:1]};
            tx_left_q  <= tx_left_q - 4'd1;
            tx_cnt_q   <= BIT_LAST;
        end
    end

endmodule

// File: rtl/uart_bus_master.sv
// Serial-to-bus bridge: parses write (57 addr[4] data[4]) and read
// (52 addr[4]) frames from the UART, issues one 32-bit bus strobe per
// frame and returns 4B (write) or the four read-data bytes (read).
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_serial_rx      serial in;  o_serial_tx serial out (idle high)
//   o_bus_*          address, write/read strobes, byte enables, write data
//   i_bus_din        read data, valid the cycle after o_bus_read
//   o_busy           high whenever a frame is being handled
module uart_bus_master
    import uart_bus_pkg::*;
#(
    parameter int CLOCK_FREQ     = 125_000_000,
    parameter int BAUD_RATE      = 115_200,
    parameter int TIMEOUT_CYCLES = 1_250_000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_serial_rx,
    output logic        o_serial_tx,
    output logic [31:0] o_bus_addr,
    output logic        o_bus_write,
    output logic        o_bus_read,
    output logic [3:0]  o_bus_size,
    output logic [31:0] o_bus_dout,
    input  logic [31:0] i_bus_din,
    output logic        o_busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_MAX  = '1;

    state_e        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic [31:0]   resp_q, resp_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [TW-1:0] to_q, to_d;
    logic          is_write_q, is_write_d;

    logic [7:0] rx_data;
    logic       rx_valid, rx_ready, rx_fire;
    logic       tx_ready, tx_valid, tx_fire;

    // Bytes arriving while a transaction or response is in flight stay
    // in the UART until the FSM is back to collecting a frame.
    assign rx_ready = (state_q == IDLE) || (state_q == ADDR) || (state_q == DATA);
    assign rx_fire  = rx_valid && rx_ready;
    assign tx_valid = (state_q == RESP);
    assign tx_fire  = tx_valid && tx_ready;

    uart #(
        .CLOCK_FREQ(CLOCK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) host_uart (
        .clk           (i_clk),
        .rst           (!i_rst_n),
        .serial_rx     (i_serial_rx),
        .serial_tx     (o_serial_tx),
        .data_in       (resp_q[31:24]),
        .data_in_valid (tx_valid),
        .data_in_ready (tx_ready),
        .data_out      (rx_data),
        .data_out_valid(rx_valid),
        .data_out_ready(rx_ready)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            addr_q     <= 32'h0;
            data_q     <= 32'h0;
            resp_q     <= 32'h0;
            cnt_q      <= 2'd0;
            to_q       <= '0;
            is_write_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            resp_q     <= resp_d;
            cnt_q      <= cnt_d;
            to_q       <= to_d;
            is_write_q <= is_write_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        resp_d     = resp_q;
        cnt_d      = cnt_q;
        to_d       = to_q;
        is_write_d = is_write_q;
        case (state_q)
            IDLE: begin
                to_d = '0;
                if (rx_fire && is_command(rx_data)) begin
                    is_write_d = (rx_data == CMD_WRITE);
                    cnt_d      = 2'd0;
                    state_d    = ADDR;
                end
            end
            ADDR, DATA: begin
                // An accepted byte wins over a timeout in the same cycle.
                if (rx_fire) begin
                    to_d  = '0;
                    cnt_d = cnt_q + 2'd1;
                    if (state_q == ADDR) addr_d = {addr_q[23:0], rx_data};
                    else                 data_d = {data_q[23:0], rx_data};
                    if (cnt_q == 2'd3) begin
                        state_d = (state_q == ADDR && is_write_q) ? DATA : BUS;
                    end
                end else if (to_q == TO_LAST) begin
                    to_d    = '0;
                    state_d = IDLE;
                end else if (to_q != TO_MAX) begin
                    to_d = to_q + 1'b1;
                end
            end
            BUS: begin
                if (is_write_q) begin
                    resp_d  = {RSP_ACK, 24'h0};
                    cnt_d   = 2'd0;
                    state_d = RESP;
                end else begin
                    state_d = RDWAIT;
                end
            end
            RDWAIT: begin
                resp_d  = i_bus_din;
                cnt_d   = 2'd3;
                state_d = RESP;
            end
            RESP: begin
                // cnt_q holds the number of response bytes left minus one.
                if (tx_fire) begin
                    resp_d = {resp_q[23:0], 8'h00};
                    cnt_d  = cnt_q - 2'd1;
                    if (cnt_q == 2'd0) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_bus_addr  = addr_q;
    assign o_bus_dout  = data_q;
    assign o_bus_write = (state_q == BUS) && is_write_q;
    assign o_bus_read  = (state_q == BUS) && !is_write_q;
    assign o_bus_size  = (state_q == BUS) ? BUS_SIZE_WORD : 4'b0000;
    assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_bus_master.sv
module tb_uart_bus_master;

    localparam int CLK_HZ = 1_600_000;
    localparam int BAUD   = 200_000;
    localparam int CPB    = CLK_HZ / BAUD;
    localparam int TO     = 400;
    localparam logic [31:0] JUNK = 32'h5A5A_5A5A;

    logic        clk;
    logic        rst_n;
    logic        serial_rx;
    logic        serial_tx;
    logic [31:0] bus_addr;
    logic        bus_write;
    logic        bus_read;
    logic [3:0]  bus_size;
    logic [31:0] bus_dout;
    logic [31:0] bus_din;
    logic        busy;

    uart_bus_master #(
        .CLOCK_FREQ    (CLK_HZ),
        .BAUD_RATE     (BAUD),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_serial_rx(serial_rx),
        .o_serial_tx(serial_tx),
        .o_bus_addr (bus_addr),
        .o_bus_write(bus_write),
        .o_bus_read (bus_read),
        .o_bus_size (bus_size),
        .o_bus_dout (bus_dout),
        .i_bus_din  (bus_din),
        .o_busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        is_write;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rdata;
    } txn_t;

    txn_t        exp_bus[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  tx_log[$];
    logic [7:0]  stim_q[$];
    int          passed = 0;
    int          total  = 0;
    int          din_phase = 0;
    logic [31:0] cur_rdata = 32'h0;
    logic [31:0] last_addr = 32'h0;
    logic [31:0] last_dout = 32'h0;
    logic [3:0]  last_size = 4'h0;
    logic        last_kind = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [7:0] txb(input int back);
        if (tx_log.size() >= back) return tx_log[tx_log.size() - back];
        return 8'hxx;
    endfunction

    // Behavioural model: parse a byte stream by the frame rules and queue
    // the bus transactions and response bytes it must produce.
    task automatic model_stream(input logic [31:0] rdata);
        int i;
        int n;
        i = 0;
        n = stim_q.size();
        while (i < n) begin
            if (stim_q[i] == 8'h57 || stim_q[i] == 8'h52) begin
                txn_t t;
                int   need;
                need = (stim_q[i] == 8'h57) ? 8 : 4;
                if (n - i - 1 < need) break;
                t.is_write = (stim_q[i] == 8'h57);
                t.addr  = {stim_q[i+1], stim_q[i+2], stim_q[i+3], stim_q[i+4]};
                t.data  = t.is_write ? {stim_q[i+5], stim_q[i+6], stim_q[i+7], stim_q[i+8]} : 32'h0;
                t.rdata = rdata;
                exp_bus.push_back(t);
                if (t.is_write) exp_tx.push_back(8'h4B);
                else for (int k = 0; k < 4; k++) exp_tx.push_back(rdata[31-8*k -: 8]);
                i += need + 1;
            end else begin
                i++;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            serial_rx = frame[k];
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_stream();
        for (int k = 0; k < stim_q.size(); k++) send_byte(stim_q[k]);
    endtask

    task automatic wait_done(input string tag);
        int cnt;
        cnt = 0;
        while ((busy || exp_tx.size() != 0 || exp_bus.size() != 0) && cnt < 6000) begin
            @(posedge clk);
            cnt++;
        end
        check({tag, "_bus_drained"}, exp_bus.size(), 0);
        check({tag, "_tx_drained"}, exp_tx.size(), 0);
        check({tag, "_idle"}, busy, 1'b0);
        repeat (4 * CPB) @(posedge clk);
        #1;
    endtask

    task automatic run(input string tag, input logic [31:0] rdata);
        model_stream(rdata);
        send_stream();
        wait_done(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},  bus_addr,  32'h0);
        check({tag, "_dout"},  bus_dout,  32'h0);
        check({tag, "_write"}, bus_write, 1'b0);
        check({tag, "_read"},  bus_read,  1'b0);
        check({tag, "_size"},  bus_size,  4'h0);
        check({tag, "_busy"},  busy,      1'b0);
        check({tag, "_tx"},    serial_tx, 1'b1);
    endtask

    // Bus compare/responder: checks every cycle, pops the expected
    // transaction on each strobe.
    initial begin
        logic prev_strobe;
        prev_strobe = 1'b0;
        forever begin
            @(negedge clk);
            check("size_vs_strobe", bus_size, (bus_write || bus_read) ? 4'hF : 4'h0);
            check("strobe_exclusive", bus_write & bus_read, 1'b0);
            if (bus_write || bus_read) begin
                check("strobe_one_cycle", prev_strobe, 1'b0);
                check("strobe_expected", exp_bus.size() > 0, 1'b1);
                if (exp_bus.size() > 0) begin
                    txn_t t;
                    t = exp_bus.pop_front();
                    check("strobe_kind", bus_write, t.is_write);
                    check("strobe_addr", bus_addr, t.addr);
                    if (t.is_write) check("strobe_dout", bus_dout, t.data);
                    else begin
                        cur_rdata = t.rdata;
                        din_phase = 1;
                    end
                end
                last_addr = bus_addr;
                last_dout = bus_dout;
                last_size = bus_size;
                last_kind = bus_write;
            end
            prev_strobe = bus_write || bus_read;
        end
    end

    // Read data is valid only in the cycle after the read strobe.
    initial begin
        bus_din = JUNK;
        forever begin
            @(posedge clk);
            #1;
            if (din_phase == 1) begin
                bus_din   = cur_rdata;
                din_phase = 2;
            end else if (din_phase == 2) begin
                bus_din   = JUNK;
                din_phase = 0;
            end
        end
    end

    // Serial decoder for the response line.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (serial_tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                check("tx_start_bit", serial_tx, 1'b0);
                for (int k = 0; k < 8; k++) begin
                    repeat (CPB) @(negedge clk);
                    b[k] = serial_tx;
                end
                repeat (CPB) @(negedge clk);
                check("tx_stop_bit", serial_tx, 1'b1);
                tx_log.push_back(b);
                $display("tx byte %02h", b);
                check("tx_expected", exp_tx.size() > 0, 1'b1);
                if (exp_tx.size() > 0) check("tx_byte", b, exp_tx.pop_front());
            end
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        serial_rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        // Write frame
        stim_q = '{8'h57, 8'h80, 8'h00, 8'h00, 8'h08, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run("write", 32'h0);
        check("pin_wr_addr", last_addr, 32'h8000_0008);
        check("pin_wr_dout", last_dout, 32'hDEAD_BEEF);
        check("pin_wr_size", last_size, 4'hF);
        check("pin_wr_kind", last_kind, 1'b1);
        check("pin_wr_ack",  txb(1), 8'h4B);
        $display("write frame done: addr %08h dout %08h", last_addr, last_dout);

        // Read frame
        stim_q = '{8'h52, 8'h00, 8'h00, 8'h10, 8'h00};
        run("read", 32'h1234_5678);
        check("pin_rd_addr", last_addr, 32'h0000_1000);
        check("pin_rd_kind", last_kind, 1'b0);
        check("pin_rd_b0", txb(4), 8'h12);
        check("pin_rd_b3", txb(1), 8'h78);
        $display("read frame done: addr %08h", last_addr);

        // Junk byte then a read
        stim_q = '{8'hFF, 8'h52, 8'h00, 8'h00, 8'h20, 8'h04};
        run("junk_read", 32'h0BAD_F00D);
        check("pin_junk_addr", last_addr, 32'h0000_2004);
        check("pin_junk_b0", txb(4), 8'h0B);
        $display("junk+read frame done: addr %08h", last_addr);

        // Partial frame then silence
        stim_q = '{8'h57, 8'h80, 8'h00};
        model_stream(32'h0);
        send_stream();
        repeat (TO / 2) @(posedge clk);
        #1;
        check("timeout_still_busy", busy, 1'b1);
        repeat (TO) @(posedge clk);
        #1;
        check("timeout_idle", busy, 1'b0);
        check("timeout_no_strobe", exp_bus.size(), 0);
        stim_q = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04};
        run("after_timeout", 32'h0);
        check("pin_to_dout", last_dout, 32'h0102_0304);
        $display("timeout recovery done: addr %08h dout %08h", last_addr, last_dout);

        // Reset in the middle of a write frame
        stim_q = '{8'h57, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        model_stream(32'h0);
        send_stream();
        check("midframe_busy", busy, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4 * CPB) @(posedge clk);
        #1;
        check("midreset_no_strobe_busy", busy, 1'b0);
        stim_q = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h40};
        run("post_reset", 32'hCAFE_F00D);
        check("pin_pr_addr", last_addr, 32'h0000_0040);
        check("pin_pr_b3", txb(1), 8'h0D);
        $display("post-reset read done: addr %08h", last_addr);

        // Back-to-back write then read
        stim_q = '{8'h57, 8'h00, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                   8'h52, 8'h00, 8'h00, 8'h01, 8'h00};
        run("b2b", 32'h1122_3344);
        check("pin_b2b_ack", txb(5), 8'h4B);
        check("pin_b2b_b0",  txb(4), 8'h11);
        check("pin_b2b_b3",  txb(1), 8'h44);
        check("pin_b2b_kind", last_kind, 1'b0);
        $display("back-to-back frames done: addr %08h", last_addr);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
